// File: rtl/ipv4_parser_if.sv
// Byte-stream bundle between the Ethernet parser, the IPv4 parser and the UDP parser.
// master drives the Ethernet side and observes the IPv4 side; slave is the parser itself.
interface ipv4_parser_if;
    logic [7:0]  eth_data_in;
    logic        eth_byte_valid;
    logic        eth_eof;
    logic        eth_err;
    logic [7:0]  ip_data_out;
    logic        ip_byte_valid;
    logic        ip_eof;
    logic        ip_err;
    logic        ip_hdr_valid;
    logic [31:0] ip_src_addr;
    logic [31:0] ip_dst_addr;
    logic [7:0]  ip_protocol;
    logic [15:0] ip_payload_len;

    modport master (
        output eth_data_in, eth_byte_valid, eth_eof, eth_err,
        input  ip_data_out, ip_byte_valid, ip_eof, ip_err, ip_hdr_valid,
        input  ip_src_addr, ip_dst_addr, ip_protocol, ip_payload_len
    );

    modport slave (
        input  eth_data_in, eth_byte_valid, eth_eof, eth_err,
        output ip_data_out, ip_byte_valid, ip_eof, ip_err, ip_hdr_valid,
        output ip_src_addr, ip_dst_addr, ip_protocol, ip_payload_len
    );
endinterface

// File: rtl/ipv4_parser.sv
// IPv4 header validator/stripper: forwards exactly total_length - IHL*4 payload bytes.
// Define IPV4_CSUM_CHECK_EN to accumulate and enforce the header checksum.
module ipv4_parser #(
    parameter logic [7:0] PROTOCOL = 8'd17
) (
    input  logic         clk,
    input  logic         rst_n,
    ipv4_parser_if.slave bus
);

    typedef enum logic [1:0] {S_HEADER, S_PAYLOAD, S_DRAIN} state_e;

    state_e      state_q;
    logic [5:0]  byte_cnt_q;
    logic [3:0]  ihl_q;
    logic [15:0] tot_len_q, tot_len_d;
    logic [13:0] frag_q, frag_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] pay_cnt_q;
    logic        trunc_q;

    logic [7:0]  data_q;
    logic        byte_vld_q, eof_q, err_q, hdr_vld_q;
    logic [31:0] src_out_q, dst_out_q;
    logic [7:0]  proto_out_q;
    logic [15:0] len_out_q;

    logic [7:0]  byte_in;
    logic [5:0]  hdr_len;
    logic        last_hdr, byte0_bad, hdr_ok, hdr_adv, csum_ok;
    logic [15:0] pay_len_d;

    assign byte_in   = bus.eth_data_in;
    assign hdr_len   = {ihl_q, 2'b00};
    assign last_hdr  = (byte_cnt_q != 6'd0) && (byte_cnt_q == hdr_len - 6'd1);
    assign byte0_bad = (byte_in[7:4] != 4'd4) || (byte_in[3:0] < 4'd5);

    // Field values including the byte being consumed, so the last header byte can be judged at once.
    always_comb begin
        tot_len_d = tot_len_q;
        frag_d    = frag_q;
        proto_d   = proto_q;
        src_d     = src_q;
        dst_d     = dst_q;
        case (byte_cnt_q)
            6'd2, 6'd3:                 tot_len_d = {tot_len_q[7:0], byte_in};
            6'd6, 6'd7:                 frag_d    = {frag_q[5:0], byte_in};
            6'd9:                       proto_d   = byte_in;
            6'd12, 6'd13, 6'd14, 6'd15: src_d     = {src_q[23:0], byte_in};
            6'd16, 6'd17, 6'd18, 6'd19: dst_d     = {dst_q[23:0], byte_in};
            default: ;
        endcase
    end

    assign pay_len_d = tot_len_d - {10'd0, hdr_len};
    assign hdr_adv   = (state_q == S_HEADER) && bus.eth_byte_valid && !bus.eth_err && !bus.eth_eof &&
                       !last_hdr && !((byte_cnt_q == 6'd0) && byte0_bad);

`ifdef IPV4_CSUM_CHECK_EN
    logic [15:0] csum_q, csum_d;
    logic [16:0] csum_sum;

    // Even offsets are the high byte of a word; carry folds back in every step.
    assign csum_sum = {1'b0, csum_q} + (byte_cnt_q[0] ? {9'd0, byte_in} : {1'b0, byte_in, 8'd0});
    assign csum_d   = csum_sum[15:0] + {15'd0, csum_sum[16]};
    assign csum_ok  = (csum_d == 16'hFFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (hdr_adv) begin
            csum_q <= csum_d;
        end else if ((state_q != S_HEADER) || bus.eth_byte_valid || bus.eth_err) begin
            csum_q <= '0;
        end
    end
`else
    assign csum_ok = 1'b1;
`endif

    assign hdr_ok = !frag_d[13] && (frag_d[12:0] == 13'd0) && (proto_d == PROTOCOL) &&
                    (tot_len_d > {10'd0, hdr_len}) && csum_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HEADER;
            byte_cnt_q  <= '0;
            ihl_q       <= '0;
            tot_len_q   <= '0;
            frag_q      <= '0;
            proto_q     <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            pay_cnt_q   <= '0;
            trunc_q     <= 1'b0;
            data_q      <= '0;
            byte_vld_q  <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
            hdr_vld_q   <= 1'b0;
            src_out_q   <= '0;
            dst_out_q   <= '0;
            proto_out_q <= '0;
            len_out_q   <= '0;
        end else begin
            byte_vld_q <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            hdr_vld_q  <= 1'b0;
            trunc_q    <= 1'b0;
            // A payload cut short by eth_eof is terminated one cycle after its last byte.
            if (trunc_q) begin
                err_q <= 1'b1;
                eof_q <= 1'b1;
            end
            case (state_q)
                S_HEADER: begin
                    if (bus.eth_err) begin
                        if (byte_cnt_q != 6'd0) err_q <= 1'b1;
                        byte_cnt_q <= '0;
                    end else if (bus.eth_byte_valid) begin
                        tot_len_q <= tot_len_d;
                        frag_q    <= frag_d;
                        proto_q   <= proto_d;
                        src_q     <= src_d;
                        dst_q     <= dst_d;
                        if (byte_cnt_q == 6'd0) ihl_q <= byte_in[3:0];
                        if ((byte_cnt_q == 6'd0) && byte0_bad) begin
                            err_q      <= 1'b1;
                            byte_cnt_q <= '0;
                            state_q    <= bus.eth_eof ? S_HEADER : S_DRAIN;
                        end else if (last_hdr) begin
                            byte_cnt_q <= '0;
                            if (hdr_ok) begin
                                hdr_vld_q   <= 1'b1;
                                src_out_q   <= src_d;
                                dst_out_q   <= dst_d;
                                proto_out_q <= proto_d;
                                len_out_q   <= pay_len_d;
                                pay_cnt_q   <= pay_len_d;
                                if (bus.eth_eof) begin
                                    err_q <= 1'b1;
                                    eof_q <= 1'b1;
                                end else begin
                                    state_q <= S_PAYLOAD;
                                end
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= bus.eth_eof ? S_HEADER : S_DRAIN;
                            end
                        end else if (bus.eth_eof) begin
                            err_q      <= 1'b1;
                            byte_cnt_q <= '0;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 6'd1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (bus.eth_err) begin
                        err_q   <= 1'b1;
                        eof_q   <= 1'b1;
                        state_q <= S_HEADER;
                    end else if (bus.eth_byte_valid) begin
                        data_q     <= byte_in;
                        byte_vld_q <= 1'b1;
                        pay_cnt_q  <= pay_cnt_q - 16'd1;
                        if (pay_cnt_q == 16'd1) begin
                            eof_q   <= 1'b1;
                            state_q <= bus.eth_eof ? S_HEADER : S_DRAIN;
                        end else if (bus.eth_eof) begin
                            trunc_q <= 1'b1;
                            state_q <= S_HEADER;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.eth_err || bus.eth_eof) state_q <= S_HEADER;
                end
                default: state_q <= S_HEADER;
            endcase
        end
    end

    assign bus.ip_data_out    = data_q;
    assign bus.ip_byte_valid  = byte_vld_q;
    assign bus.ip_eof         = eof_q;
    assign bus.ip_err         = err_q;
    assign bus.ip_hdr_valid   = hdr_vld_q;
    assign bus.ip_src_addr    = src_out_q;
    assign bus.ip_dst_addr    = dst_out_q;
    assign bus.ip_protocol    = proto_out_q;
    assign bus.ip_payload_len = len_out_q;

endmodule
